// File: rtl/memory_access_stage.sv
// memory_access_stage: single-entry memory access stage between execute and
// writeback. Computes the effective address, issues one load/store request,
// extends load data and hands the result on with its pass-through payload.
// Optional alignment check: define MEM_ALIGN_CHECK_EN to fault misaligned
// loads/stores instead of issuing them.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | empty, ready to accept an instruction
// REQ   | memory request presented, waiting for memReqReady
// WAIT  | request accepted by memory, waiting for memRespValid
// DONE  | result held on the output until writeback takes it
module memory_access_stage #(
  parameter int DATA_WIDTH    = 64,
  parameter int PAYLOAD_WIDTH = 256,
  parameter int DISP_WIDTH    = 32
) (
  input  logic                     clk,
  input  logic                     resetN,
  input  logic                     inValid,
  output logic                     inReady,
  input  logic [1:0]               memOpIn,
  input  logic [1:0]               memSizeIn,
  input  logic                     loadSignedIn,
  input  logic [DATA_WIDTH-1:0]    baseIn,
  input  logic [DISP_WIDTH-1:0]    dispIn,
  input  logic [DATA_WIDTH-1:0]    storeDataIn,
  input  logic [PAYLOAD_WIDTH-1:0] payloadIn,
  output logic                     memReqValid,
  input  logic                     memReqReady,
  output logic                     memReqWrite,
  output logic [DATA_WIDTH-1:0]    memReqAddr,
  output logic [1:0]               memReqSize,
  output logic [DATA_WIDTH-1:0]    memReqData,
  input  logic                     memRespValid,
  input  logic [DATA_WIDTH-1:0]    memRespData,
  output logic                     outValid,
  input  logic                     outReady,
  output logic [DATA_WIDTH-1:0]    resultOut,
  output logic [PAYLOAD_WIDTH-1:0] payloadOut,
  output logic                     faultOut
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t                   state_q, state_d;
  logic [DATA_WIDTH-1:0]    addr_q, addr_d;
  logic [DATA_WIDTH-1:0]    data_q, data_d;
  logic                     write_q, write_d;
  logic [1:0]               size_q, size_d;
  logic                     signed_q, signed_d;
  logic [DATA_WIDTH-1:0]    result_q, result_d;
  logic [PAYLOAD_WIDTH-1:0] payload_q, payload_d;
  logic                     fault_q, fault_d;

  logic                  accept;
  logic                  is_mem;
  logic                  misaligned;
  logic [DATA_WIDTH-1:0] eff_addr;

  // Truncate returned data to the access size, then zero/sign extend.
  function automatic logic [DATA_WIDTH-1:0] load_ext(
    input logic [DATA_WIDTH-1:0] d,
    input logic [1:0]            sz,
    input logic                  sgn
  );
    logic [DATA_WIDTH-1:0] r;
    case (sz)
      2'd0:    r = {{(DATA_WIDTH-8){sgn & d[7]}}, d[7:0]};
      2'd1:    r = {{(DATA_WIDTH-16){sgn & d[15]}}, d[15:0]};
      2'd2:    r = {{(DATA_WIDTH-32){sgn & d[31]}}, d[31:0]};
      default: r = d;
    endcase
    return r;
  endfunction

  assign eff_addr = baseIn + {{(DATA_WIDTH-DISP_WIDTH){dispIn[DISP_WIDTH-1]}}, dispIn};
  // Reserved op code 3 behaves as "none".
  assign is_mem   = (memOpIn == 2'd1) || (memOpIn == 2'd2);

`ifdef MEM_ALIGN_CHECK_EN
  // Address must be a multiple of the access size.
  always_comb begin
    misaligned = 1'b0;
    case (memSizeIn)
      2'd0:    misaligned = 1'b0;
      2'd1:    misaligned = eff_addr[0];
      2'd2:    misaligned = |eff_addr[1:0];
      default: misaligned = |eff_addr[2:0];
    endcase
  end
`else
  assign misaligned = 1'b0;
`endif

  assign inReady = (state_q == S_IDLE) || ((state_q == S_DONE) && outReady);
  assign accept  = inValid && inReady;

  // Next-state and datapath update; an accept in DONE overrides the return to IDLE.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    data_d    = data_q;
    write_d   = write_q;
    size_d    = size_q;
    signed_d  = signed_q;
    result_d  = result_q;
    payload_d = payload_q;
    fault_d   = fault_q;

    case (state_q)
      S_REQ: begin
        if (memReqReady) begin
          if (memRespValid) begin
            state_d  = S_DONE;
            result_d = write_q ? '0 : load_ext(memRespData, size_q, signed_q);
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (memRespValid) begin
          state_d  = S_DONE;
          result_d = write_q ? '0 : load_ext(memRespData, size_q, signed_q);
        end
      end
      S_DONE: begin
        if (outReady) state_d = S_IDLE;
      end
      default: state_d = state_q;
    endcase

    if (accept) begin
      payload_d = payloadIn;
      addr_d    = eff_addr;
      data_d    = storeDataIn;
      write_d   = (memOpIn == 2'd2);
      size_d    = memSizeIn;
      signed_d  = loadSignedIn;
      fault_d   = is_mem && misaligned;
      result_d  = is_mem ? '0 : baseIn;
      state_d   = (is_mem && !misaligned) ? S_REQ : S_DONE;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      data_q    <= '0;
      write_q   <= 1'b0;
      size_q    <= 2'd0;
      signed_q  <= 1'b0;
      result_q  <= '0;
      payload_q <= '0;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      write_q   <= write_d;
      size_q    <= size_d;
      signed_q  <= signed_d;
      result_q  <= result_d;
      payload_q <= payload_d;
      fault_q   <= fault_d;
    end
  end

  assign memReqValid = (state_q == S_REQ);
  assign memReqWrite = write_q;
  assign memReqAddr  = addr_q;
  assign memReqSize  = size_q;
  assign memReqData  = data_q;
  assign outValid    = (state_q == S_DONE);
  assign resultOut   = result_q;
  assign payloadOut  = payload_q;
  assign faultOut    = fault_q;

endmodule

// File: tb/tb_memory_access_stage.sv
// Self-checking bench for memory_access_stage: directed scenarios plus
// randomized transactions compared against a behavioural model.
module tb_memory_access_stage;

  logic         clk = 1'b0;
  logic         resetN;
  logic         inValid;
  logic         inReady;
  logic [1:0]   memOpIn;
  logic [1:0]   memSizeIn;
  logic         loadSignedIn;
  logic [63:0]  baseIn;
  logic [31:0]  dispIn;
  logic [63:0]  storeDataIn;
  logic [255:0] payloadIn;
  logic         memReqValid;
  logic         memReqReady;
  logic         memReqWrite;
  logic [63:0]  memReqAddr;
  logic [1:0]   memReqSize;
  logic [63:0]  memReqData;
  logic         memRespValid;
  logic [63:0]  memRespData;
  logic         outValid;
  logic         outReady;
  logic [63:0]  resultOut;
  logic [255:0] payloadOut;
  logic         faultOut;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef MEM_ALIGN_CHECK_EN
  localparam bit ALIGN_CHK = 1'b1;
`else
  localparam bit ALIGN_CHK = 1'b0;
`endif

  memory_access_stage dut (
    .clk(clk), .resetN(resetN),
    .inValid(inValid), .inReady(inReady),
    .memOpIn(memOpIn), .memSizeIn(memSizeIn), .loadSignedIn(loadSignedIn),
    .baseIn(baseIn), .dispIn(dispIn), .storeDataIn(storeDataIn), .payloadIn(payloadIn),
    .memReqValid(memReqValid), .memReqReady(memReqReady), .memReqWrite(memReqWrite),
    .memReqAddr(memReqAddr), .memReqSize(memReqSize), .memReqData(memReqData),
    .memRespValid(memRespValid), .memRespData(memRespData),
    .outValid(outValid), .outReady(outReady),
    .resultOut(resultOut), .payloadOut(payloadOut), .faultOut(faultOut)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Behavioural model: load value of 2^sz bytes, optionally sign-extended.
  function automatic logic [63:0] model_load(input logic [63:0] d, input int sz, input bit sgn);
    int          nbits;
    logic [63:0] mask;
    logic [63:0] v;
    nbits = 8 * (1 << sz);
    if (nbits == 64) return d;
    mask = (64'd1 << nbits) - 64'd1;
    v = d & mask;
    if (sgn && d[nbits-1]) v = v | ~mask;
    return v;
  endfunction

  function automatic logic [63:0] model_ea(input logic [63:0] base, input logic [31:0] disp);
    longint signed ds;
    ds = longint'($signed(disp));
    return base + 64'(ds);
  endfunction

  task automatic run_txn(input logic [1:0] op, input logic [1:0] sz, input logic sgn,
                         input logic [63:0] base, input logic [31:0] disp,
                         input logic [63:0] sdata, input logic [63:0] rdata,
                         input logic [255:0] pl, input int req_dly, input int resp_dly,
                         input int out_dly);
    logic [63:0] ea;
    bit          is_mem;
    bit          flt;
    logic [63:0] exp_res;
    int          n;
    ea      = model_ea(base, disp);
    is_mem  = (op == 2'd1) || (op == 2'd2);
    flt     = is_mem && ALIGN_CHK && ((ea % (64'd1 << sz)) != 64'd0);
    if (!is_mem)        exp_res = base;
    else if (flt)       exp_res = 64'd0;
    else if (op == 2'd2) exp_res = 64'd0;
    else                exp_res = model_load(rdata, int'(sz), sgn);

    @(negedge clk);
    memOpIn = op; memSizeIn = sz; loadSignedIn = sgn; baseIn = base; dispIn = disp;
    storeDataIn = sdata; payloadIn = pl; inValid = 1'b1;
    n = 0;
    while (!inReady && n < 50) begin @(negedge clk); n++; end
    if (!inReady) chk("accept_timeout", 256'(inReady), 256'(1));
    @(posedge clk);
    #1 inValid = 1'b0;
    baseIn = {$urandom, $urandom};
    payloadIn = '0;
    @(negedge clk);
    if (is_mem && !flt) begin
      chk("req_valid", 256'(memReqValid), 256'(1));
      chk("req_addr", 256'(memReqAddr), 256'(ea));
      chk("req_write", 256'(memReqWrite), 256'(op == 2'd2));
      chk("req_size", 256'(memReqSize), 256'(sz));
      if (op == 2'd2) chk("req_data", 256'(memReqData), 256'(sdata));
      for (int i = 0; i < req_dly; i++) begin
        @(negedge clk);
        chk("req_hold_valid", 256'(memReqValid), 256'(1));
        chk("req_hold_addr", 256'(memReqAddr), 256'(ea));
        chk("busy_in_ready", 256'(inReady), 256'(0));
      end
      memReqReady = 1'b1;
      if (resp_dly == 0) begin memRespValid = 1'b1; memRespData = rdata; end
      @(posedge clk);
      #1 memReqReady = 1'b0; memRespValid = 1'b0;
      if (resp_dly > 0) begin
        for (int i = 1; i < resp_dly; i++) @(posedge clk);
        @(negedge clk);
        chk("wait_no_out", 256'(outValid), 256'(0));
        memRespValid = 1'b1; memRespData = rdata;
        @(posedge clk);
        #1 memRespValid = 1'b0;
        memRespData = {$urandom, $urandom};
      end
      @(negedge clk);
    end else begin
      chk("no_req", 256'(memReqValid), 256'(0));
    end
    chk("out_valid", 256'(outValid), 256'(1));
    for (int i = 0; i <= out_dly; i++) begin
      chk("result", 256'(resultOut), 256'(exp_res));
      chk("fault", 256'(faultOut), 256'(flt));
      chk("payload", payloadOut, pl);
      if (i < out_dly) @(negedge clk);
    end
    outReady = 1'b1;
    @(posedge clk);
    #1 outReady = 1'b0;
  endtask

  initial begin
    logic [255:0] pl;
    resetN = 1'b0; inValid = 1'b0; memOpIn = 2'd0; memSizeIn = 2'd0; loadSignedIn = 1'b0;
    baseIn = '0; dispIn = '0; storeDataIn = '0; payloadIn = '0; memReqReady = 1'b0;
    memRespValid = 1'b0; memRespData = '0; outReady = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_out_valid", 256'(outValid), 256'(0));
    chk("rst_req_valid", 256'(memReqValid), 256'(0));
    chk("rst_fault", 256'(faultOut), 256'(0));
    chk("rst_result", 256'(resultOut), 256'(0));
    chk("rst_payload", payloadOut, 256'(0));
    resetN = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", 256'(inReady), 256'(1));

    // Op none, 1-cycle latency, result = base
    run_txn(2'd0, 2'd0, 1'b0, 64'h1234, 32'h0, 64'h0, 64'h0, 256'hA5, 0, 0, 0);
    // Signed byte load with negative displacement
    run_txn(2'd1, 2'd0, 1'b1, 64'h1000, 32'hFFFF_FFF0, 64'h0, 64'h80, 256'h11, 0, 1, 0);
    // Store held 3 cycles by memReqReady low
    run_txn(2'd2, 2'd3, 1'b0, 64'h2000, 32'h8, 64'hDEAD_BEEF_0123_4567, 64'h0, 256'h22, 3, 2, 0);
    // Output back-pressure for 4 cycles
    run_txn(2'd1, 2'd1, 1'b0, 64'h3000, 32'h2, 64'h0, 64'hFFFF_8001, 256'h33, 0, 0, 4);
    // Misaligned word load: faults or issues depending on build
    run_txn(2'd1, 2'd2, 1'b0, 64'h1002, 32'h0, 64'h0, 64'h1234_5678, 256'h44, 0, 1, 0);
    // Address wrap
    run_txn(2'd1, 2'd3, 1'b0, 64'hFFFF_FFFF_FFFF_FFF8, 32'h10, 64'h0, 64'h0102_0304_0506_0708, 256'h55, 1, 0, 0);
    // Reserved op behaves as none
    run_txn(2'd3, 2'd1, 1'b1, 64'hCAFE, 32'h40, 64'h0, 64'h0, 256'h66, 0, 0, 1);

    // Back-to-back op-none accepts
    @(negedge clk);
    memOpIn = 2'd0; baseIn = 64'hAAAA; payloadIn = 256'h1; inValid = 1'b1; outReady = 1'b1;
    @(posedge clk);
    #1 baseIn = 64'hBBBB; payloadIn = 256'h2;
    @(negedge clk);
    chk("b2b_first_valid", 256'(outValid), 256'(1));
    chk("b2b_first_result", 256'(resultOut), 256'(64'hAAAA));
    chk("b2b_in_ready", 256'(inReady), 256'(1));
    @(posedge clk);
    #1 inValid = 1'b0;
    @(negedge clk);
    chk("b2b_second_valid", 256'(outValid), 256'(1));
    chk("b2b_second_result", 256'(resultOut), 256'(64'hBBBB));
    chk("b2b_second_payload", payloadOut, 256'h2);
    @(negedge clk);
    chk("b2b_drained", 256'(outValid), 256'(0));
    outReady = 1'b0;

    // Reset while in WAIT, then a late response
    @(negedge clk);
    memOpIn = 2'd1; memSizeIn = 2'd3; baseIn = 64'h4000; dispIn = '0; inValid = 1'b1;
    @(posedge clk);
    #1 inValid = 1'b0;
    @(negedge clk);
    memReqReady = 1'b1;
    @(posedge clk);
    #1 memReqReady = 1'b0;
    @(negedge clk);
    chk("wait_before_rst", 256'(memReqValid | outValid), 256'(0));
    resetN = 1'b0;
    #2;
    chk("rst_mid_out_valid", 256'(outValid), 256'(0));
    chk("rst_mid_result", 256'(resultOut), 256'(0));
    @(negedge clk);
    resetN = 1'b1;
    @(negedge clk);
    memRespValid = 1'b1; memRespData = 64'h55;
    @(posedge clk);
    #1 memRespValid = 1'b0;
    @(negedge clk);
    chk("late_resp_out_valid", 256'(outValid), 256'(0));
    chk("late_resp_req_valid", 256'(memReqValid), 256'(0));
    chk("late_resp_in_ready", 256'(inReady), 256'(1));

    // Randomized transactions
    for (int t = 0; t < 40; t++) begin
      pl = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      run_txn(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
              {$urandom, $urandom}, $urandom, {$urandom, $urandom}, {$urandom, $urandom},
              pl, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
